adc_stream_arbiter: RTL and testbench

Parametrised N-channel round-robin merger placed between the per-channel ADC receiver FIFOs and the SRAM output FIFO. It is the successor to the fixed 4-channel round-robin arbiter. It adds:
- configurable channel count and data width;
- per-channel enable mask;
- burst-length fairness with a hold override;
- optional channel-ID tagging;
- a registered valid/ready output that sustains one word per cycle within a burst.

---
 rtl/adc_stream_arbiter_pkg.sv | 13 +
 rtl/adc_stream_arbiter_rr_select.sv | 20 ++
 rtl/adc_stream_arbiter.sv | 79 +++++++
 tb/tb_adc_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_stream_arbiter_pkg.sv
// adc_stream_arbiter_pkg: shared FSM state, defaults and clog2 helper for the stream arbiter
package adc_stream_arbiter_pkg;
  typedef enum logic {ARB, BURST} state_t;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_BITS = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < n; i++) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/adc_stream_arbiter_rr_select.sv
// rr_select: combinational rotate-priority find-first, searching upward from ptr with wrap
module rr_select
  import adc_stream_arbiter_pkg::*;
#(
  parameter int N = DEF_CHANNELS,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [2*N-1:0] dbl;
  always_comb begin
    dbl = {req, req} >> ptr;
    idx = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--) if (dbl[i]) idx = W'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/adc_stream_arbiter.sv
// adc_stream_arbiter: N-channel round-robin burst merger with enable mask, hold override and ID tagging
module adc_stream_arbiter
  import adc_stream_arbiter_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_TAG     = 1,
  parameter int ID_BITS    = DEF_ID_BITS,
  parameter int BURST_W    = 8
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST_N,
  input  logic [CHANNELS-1:0]            CH_EN,
  input  logic [BURST_W-1:0]             BURST_LEN,
  input  logic [CHANNELS-1:0]            WRITE_REQ,
  input  logic [CHANNELS-1:0]            HOLD_REQ,
  input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
  output logic [CHANNELS-1:0]            READ_GRANT,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [DATA_WIDTH-1:0]          OUT_DATA,
  output logic [ID_BITS-1:0]             CUR_CH,
  output logic                           BUSY
);
  state_t state_q, state_d;
  logic [ID_BITS-1:0] ptr_q, ptr_d, cur_q, cur_d, sel_idx;
  logic [BURST_W-1:0] cnt_q, cnt_d, limit;
  logic out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, raw, word;
  logic [CHANNELS-1:0] cur_oh;
  logic sel_found, wr_c, en_c, hold_c, below, pop, leave;
  rr_select #(.N(CHANNELS), .W(ID_BITS)) u_sel (
    .req  (WRITE_REQ & CH_EN),
    .ptr  (ptr_q),
    .idx  (sel_idx),
    .found(sel_found)
  );
  always_comb begin
    cur_oh = CHANNELS'(1) << cur_q;
    wr_c = |(WRITE_REQ & cur_oh);
    en_c = |(CH_EN & cur_oh);
    hold_c = |(HOLD_REQ & cur_oh);
    limit = (BURST_LEN == '0) ? BURST_W'(1) : BURST_LEN;
    below = cnt_q < limit;
    raw = DATA_WIDTH'(DATA_IN >> (int'(cur_q) * DATA_WIDTH));
    word = (ID_TAG != 0) ? {cur_q, raw[DATA_WIDTH-ID_BITS-1:0]} : raw;
    pop = (state_q == BURST) && wr_c && en_c && (!out_valid_q || OUT_READY) && (below || hold_c);
    // exit is decided on the registered count, so the exit cycle never pops
    leave = (state_q == BURST) && ((!below && !hold_c) || !wr_c || !en_c);
    state_d = (state_q == ARB) ? (sel_found ? BURST : ARB) : (leave ? ARB : BURST);
    cur_d = (state_q == ARB && sel_found) ? sel_idx : cur_q;
    cnt_d = (state_q == ARB) ? '0 : (pop && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    ptr_d = leave ? ((int'(cur_q) == CHANNELS - 1) ? '0 : cur_q + 1'b1) : ptr_q;
    out_valid_d = pop | (out_valid_q & ~OUT_READY);
    out_data_d = pop ? word : out_data_q;
  end
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= ARB;
      ptr_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign READ_GRANT = pop ? cur_oh : '0;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA = out_data_q;
  assign CUR_CH = cur_q;
  assign BUSY = (state_q == BURST);
endmodule

// File: tb/tb_adc_stream_arbiter.sv
// tb_adc_stream_arbiter: directed scoreboard bench for the 4-channel default configuration
module tb_adc_stream_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] CH_EN, WRITE_REQ, HOLD_REQ, READ_GRANT, CUR_CH;
  logic [7:0] BURST_LEN;
  logic [127:0] DATA_IN;
  logic OUT_VALID, OUT_READY, BUSY;
  logic [31:0] OUT_DATA;
  int vec = 0;
  int err = 0;
  int cyc = 0;
  int hold_left = 0;
  int lc;
  bit rnd = 1'b0;
  logic [31:0] src [4][$];
  logic [31:0] expq [4][$];
  int glog[$];
  int gcyc[$];
  int eg[$];
  always #5 clk = ~clk;
  adc_stream_arbiter dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_EN(CH_EN), .BURST_LEN(BURST_LEN),
    .WRITE_REQ(WRITE_REQ), .HOLD_REQ(HOLD_REQ), .DATA_IN(DATA_IN),
    .READ_GRANT(READ_GRANT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .CUR_CH(CUR_CH), .BUSY(BUSY)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      WRITE_REQ[c] = src[c].size() != 0;
      if (src[c].size() != 0) DATA_IN[c*32 +: 32] = src[c][0];
      else DATA_IN[c*32 +: 32] = 32'h0;
    end
    HOLD_REQ = (hold_left > 0) ? 4'b0100 : 4'b0000;
    OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  task automatic load(input int c, input int n, input int id);
    logic [31:0] raw;
    for (int i = 0; i < n; i++) begin
      raw = {4'(c) ^ 4'hA, 8'(id), 20'(i)};
      src[c].push_back(raw);
      expq[c].push_back({4'(c), raw[27:0]});
    end
  endtask
  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      src[c].delete();
      expq[c].delete();
    end
    hold_left = 0;
    rnd = 1'b0;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    clear_model();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete();
    gcyc.delete();
  endtask
  task automatic step();
    logic [3:0] rg;
    logic ov, rdy;
    logic [31:0] od, dummy;
    int ch, g;
    @(negedge clk);
    rg = READ_GRANT;
    ov = OUT_VALID;
    od = OUT_DATA;
    rdy = OUT_READY;
    if (ov && rdy) begin
      ch = int'(od[31:28]);
      if (ch < 4 && expq[ch].size() != 0) chk("out_word", od, expq[ch].pop_front());
      else chk("out_unexpected", od, 32'hFFFF_FFFF);
    end
    if (ov && !rdy) chk("stall_grant", 32'(rg), 32'h0);
    if (rg != 4'b0) begin
      chk("grant_onehot", 32'($countones(rg)), 32'd1);
      g = 0;
      for (int i = 0; i < 4; i++) if (rg[i]) g = i;
      glog.push_back(g);
      gcyc.push_back(cyc);
      if (src[g].size() != 0) dummy = src[g].pop_front();
      else chk("grant_empty_src", 32'(g), 32'hFFFF_FFFF);
      if (g == 2 && hold_left > 0) hold_left--;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask
  function automatic bit src_busy();
    for (int c = 0; c < 4; c++) if (src[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((src_busy() || OUT_VALID) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask
  task automatic check_log(input string tag);
    chk({tag, "_grant_count_min"}, 32'(glog.size() >= eg.size()), 32'd1);
    for (int i = 0; i < eg.size() && i < glog.size(); i++)
      chk($sformatf("%s_grant%0d", tag, i), 32'(glog[i]), 32'(eg[i]));
  endtask
  task automatic check_sb(input string tag);
    for (int c = 0; c < 4; c++) chk($sformatf("%s_missing_ch%0d", tag, c), 32'(expq[c].size()), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    CH_EN = 4'hF;
    BURST_LEN = 8'd2;
    WRITE_REQ = 4'h0;
    HOLD_REQ = 4'h0;
    DATA_IN = '0;
    OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_grant", 32'(READ_GRANT), 32'h0);
    chk("rst_valid", 32'(OUT_VALID), 32'h0);
    chk("rst_data", OUT_DATA, 32'h0);
    chk("rst_cur", 32'(CUR_CH), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    // fairness, tagging, latency and inter-burst gap
    reset_dut();
    BURST_LEN = 8'd2;
    for (int c = 0; c < 4; c++) load(c, 8, 1);
    drive();
    lc = cyc;
    run_until_empty(400);
    eg = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
    check_log("fair");
    chk("fair_latency", 32'(gcyc[0] - lc), 32'd1);
    chk("fair_in_burst_gap", 32'(gcyc[1] - gcyc[0]), 32'd1);
    chk("fair_burst_gap", 32'(gcyc[2] - gcyc[1]), 32'd3);
    check_sb("fair");
    // enable mask
    reset_dut();
    CH_EN = 4'b1010;
    BURST_LEN = 8'd1;
    for (int c = 0; c < 4; c++) load(c, 4, 2);
    drive();
    repeat (40) step();
    eg = '{1, 3, 1, 3, 1, 3, 1, 3};
    check_log("mask");
    chk("mask_count", 32'(glog.size()), 32'd8);
    CH_EN = 4'hF;
    run_until_empty(200);
    check_sb("mask");
    // hold override
    reset_dut();
    BURST_LEN = 8'd1;
    load(0, 3, 3);
    load(1, 3, 3);
    load(2, 12, 3);
    load(3, 3, 3);
    hold_left = 10;
    drive();
    run_until_empty(300);
    eg = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    check_log("hold");
    check_sb("hold");
    // random backpressure with counter streams
    reset_dut();
    BURST_LEN = 8'd3;
    rnd = 1'b1;
    for (int c = 0; c < 4; c++) load(c, 16, 4);
    drive();
    run_until_empty(2000);
    rnd = 1'b0;
    check_sb("bp");
    // zero burst length acts as one
    reset_dut();
    BURST_LEN = 8'd0;
    load(0, 2, 5);
    load(1, 2, 5);
    drive();
    run_until_empty(100);
    eg = '{0, 1, 0, 1};
    check_log("len0");
    check_sb("len0");
    // source empties mid-burst, pointer advances and wraps
    reset_dut();
    BURST_LEN = 8'd8;
    load(0, 3, 6);
    load(1, 3, 6);
    drive();
    run_until_empty(100);
    load(0, 1, 7);
    load(3, 1, 7);
    drive();
    run_until_empty(100);
    eg = '{0, 0, 0, 1, 1, 1, 3, 0};
    check_log("empty");
    check_sb("empty");
    // asynchronous reset mid-burst
    reset_dut();
    BURST_LEN = 8'd4;
    load(2, 4, 8);
    drive();
    repeat (3) step();
    chk("pre_rst_valid", 32'(OUT_VALID), 32'd1);
    chk("pre_rst_busy", 32'(BUSY), 32'd1);
    chk("pre_rst_cur", 32'(CUR_CH), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(READ_GRANT), 32'h0);
    chk("arst_valid", 32'(OUT_VALID), 32'h0);
    chk("arst_data", OUT_DATA, 32'h0);
    chk("arst_cur", 32'(CUR_CH), 32'h0);
    chk("arst_busy", 32'(BUSY), 32'h0);
    clear_model();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete();
    gcyc.delete();
    load(3, 2, 9);
    load(1, 2, 9);
    drive();
    run_until_empty(100);
    eg = '{1, 1, 3, 3};
    check_log("post_rst");
    check_sb("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
